// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN (signed overflow output).
package serial_subtractor_pkg;

  // FSM encoding, kept as plain 2-bit constants for legacy tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Bit-counter width; never narrower than one bit
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor, LSB first, single registered borrow.
// Handshaked on both sides; one result per WIDTH+2 cycles.
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds registered signed
// overflow output ovf, valid alongside out_valid.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             br_q, bo_q;
  logic             d_w, br_nx;
  logic             last_bit;

  // Single datapath cell: current LSBs plus the running borrow
  full_subtractor u_fs (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (d_w),
    .bo (br_nx)
  );

  assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST);

  // Next-state logic; in_valid is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand shifters, borrow, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        br_q  <= bi;
        cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        a_q    <= a_q >> 1;
        b_q    <= b_q >> 1;
        br_q   <= br_nx;
        diff_q <= {d_w, diff_q[WIDTH-1:1]};
        // Counter restarts via the state transition, not by wrapping
        cnt_q  <= last_bit ? '0 : cnt_q + CNT_W'(1);
        if (last_bit) bo_q <= br_nx;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_q;

  // In the final bit a_q[0]/b_q[0] hold the operand MSBs and d_w the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_w);
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif
  localparam logic [W-1:0] MASK = '1;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bi = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`else
  logic         ovf = 1'b0;
`endif

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bo        (bo)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("bo", 32'(bo), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  // Present operands once in_ready is seen; returns just after the accepting edge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic biv,
                       input logic [W-1:0] ed, input logic ebo, input logic eov,
                       input bit push);
    int t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    a = av; b = bv; bi = biv; in_valid = 1'b1;
    e.d = ed; e.bo = ebo; e.ov = eov;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges to out_valid; the accepting edge counts as the first
  task automatic wait_valid(input bit check_lat);
    int n;
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    else if (check_lat) chk("latency_edges", 32'(n), 32'(W + 1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bo", 32'(bo), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic vectors (expected values hand-computed, masked to W bits)
    issue(W'(5), W'(3), 1'b0, W'(2), 1'b0, 1'b0, 1'b1);  wait_valid(1'b1);
    issue(W'(3), W'(5), 1'b0, 8'hFE & MASK, 1'b1, 1'b0, 1'b1); wait_valid(1'b1);
    issue(W'(0), W'(0), 1'b1, MASK, 1'b1, 1'b0, 1'b1);   wait_valid(1'b1);
    issue(W'(0), MASK, 1'b1, W'(0), 1'b1, 1'b0, 1'b1);   wait_valid(1'b0);
    issue(W'(7), W'(7), 1'b0, W'(0), 1'b0, 1'b0, 1'b1);  wait_valid(1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);  wait_valid(1'b1);
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);  wait_valid(1'b0);
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);  wait_valid(1'b0);
`endif

    // Backpressure: hold result for 6 cycles; 9-4 = 5, no borrow
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(W'(9), W'(4), 1'b0, W'(5), 1'b0, 1'b0, 1'b1);
    wait_valid(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(diff), 32'd5);
      chk("bp_bo", 32'(bo), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);

    // in_valid held with changing operands during RUN: 12-7-1 = 4
    a = W'(12); b = W'(7); bi = 1'b1; in_valid = 1'b1;
    begin
      exp_t e;
      e.d = W'(4); e.bo = 1'b0; e.ov = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("hold_reached_done", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Reset in the second RUN cycle: abandon, nothing flagged valid
    issue(W'(6), W'(1), 1'b0, W'(5), 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_diff", 32'(diff), 32'd0);
    chk("midrun_bo", 32'(bo), 32'd0);
    chk("midrun_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (out_valid) chk("no_valid_after_abort", 32'(out_valid), 32'd0);
    end

    // One more op after the abort
    issue(W'(1), W'(2), 1'b0, MASK, 1'b1, 1'b0, 1'b1); wait_valid(1'b1);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
